// File: rtl/decoder_n.sv
// decoder_n: registered binary-to-one-hot decoder with level and counted-pulse output modes
module decoder_n #(
   parameter int SEL_W = 2,
   parameter int HOLD_W = 4,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SEL_W-1:0]  sel,
   input  logic              mode,
   input  logic [HOLD_W-1:0] hold,
   input  logic              clr,
   output logic [OUT_W-1:0]  d,
   output logic              busy
);
   typedef enum logic {IDLE, HOLD} state_t;
   localparam logic [OUT_W-1:0] INACT = {OUT_W{ACTIVE_LOW}};
   state_t state, state_n;
   logic [HOLD_W-1:0] cnt, cnt_n;
   logic [OUT_W-1:0] d_n, dec;
   logic accept;
   assign in_ready = state == IDLE;
   assign busy = state == HOLD;
   assign accept = in_valid & in_ready;
   assign dec = (OUT_W'(1) << sel) ^ INACT;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      d_n = d;
      if (state == IDLE) begin
         if (accept) begin
            d_n = dec;
            cnt_n = mode ? hold : cnt;
            state_n = mode ? HOLD : IDLE;
         end else if (clr) begin
            d_n = INACT;
         end
      end else begin
         // clr aborts; a zero count ends the pulse on this edge
         if (clr || cnt == '0) begin
            d_n = INACT;
            state_n = IDLE;
            cnt_n = '0;
         end else begin
            cnt_n = cnt - 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         d <= INACT;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         d <= d_n;
      end
   end
endmodule

// File: tb/tb_decoder_n.sv
// tb_decoder_n: directed scoreboard bench over three decoder_n configurations
module tb_decoder_n;
  logic clk = 1'b0;
  logic rst, in_valid, mode, clr;
  logic [2:0] sel;
  logic [3:0] hold;
  logic r0, r1, r2, b0, b1, b2;
  logic [3:0] d0, d2;
  logic [7:0] d1;
  logic done = 1'b0;
  int which = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    string tag;
    logic [7:0] d;
    logic b;
    logic r;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] od;
  logic ob, orr;
  always #5 clk = ~clk;
  decoder_n #(.SEL_W(2), .HOLD_W(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .sel(sel[1:0]),
    .mode(mode), .hold(hold), .clr(clr), .d(d0), .busy(b0));
  decoder_n #(.SEL_W(3), .HOLD_W(4), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .sel(sel),
    .mode(mode), .hold(hold), .clr(clr), .d(d1), .busy(b1));
  decoder_n #(.SEL_W(2), .HOLD_W(4), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .sel(sel[1:0]),
    .mode(mode), .hold(hold), .clr(clr), .d(d2), .busy(b2));
  always_comb begin
    od = which == 0 ? {4'b0, d0} : which == 1 ? d1 : {4'b0, d2};
    ob = which == 0 ? b0 : which == 1 ? b1 : b2;
    orr = which == 0 ? r0 : which == 1 ? r1 : r2;
  end
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert ({od, ob, orr} === {e.d, e.b, e.r}) else begin
        bad++;
        $error("FAIL %s: d=%h busy=%b rdy=%b, expected d=%h busy=%b rdy=%b",
               e.tag, od, ob, orr, e.d, e.b, e.r);
      end
    end
  end
  initial begin
    #100000;
    if (!done) begin
      bad++;
      $error("FAIL timeout: test did not finish");
      $finish;
    end
  end
  task automatic step(input string tag, input logic [7:0] ed, input logic eb, input logic er);
    q.push_back('{tag, ed, eb, er});
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1; in_valid = 0; mode = 0; clr = 0; sel = 0; hold = 0;
    @(posedge clk);
    #2;
    step("rst", 8'h0, 0, 1);
    rst = 0;
    step("rst_rel", 8'h0, 0, 1);
    if (d0 !== 4'b0000 || b0 !== 1'b0 || r0 !== 1'b1) begin
      bad++;
      $error("FAIL reset state: d=%b busy=%b rdy=%b", d0, b0, r0);
    end
    in_valid = 1; mode = 0;
    sel = 0; step("lv0", 8'h1, 0, 1);
    sel = 1; step("lv1", 8'h2, 0, 1);
    sel = 2; step("lv2", 8'h4, 0, 1);
    sel = 3; step("lv3", 8'h8, 0, 1);
    in_valid = 0; clr = 1;
    step("lv_clr", 8'h0, 0, 1);
    in_valid = 1; sel = 2;
    step("acc_clr", 8'h4, 0, 1);
    in_valid = 0; clr = 1; which = 1;
    step("w1_clr", 8'h0, 0, 1);
    clr = 0; in_valid = 1; mode = 1; sel = 5; hold = 3;
    step("p5_1", 8'h20, 1, 0);
    mode = 0; sel = 1;
    step("p5_2", 8'h20, 1, 0);
    step("p5_3", 8'h20, 1, 0);
    step("p5_4", 8'h20, 1, 0);
    step("p5_end", 8'h0, 0, 1);
    step("held_acc", 8'h2, 0, 1);
    mode = 1; sel = 7; hold = 0;
    step("h0", 8'h80, 1, 0);
    in_valid = 0;
    step("h0_end", 8'h0, 0, 1);
    in_valid = 1; sel = 3; hold = 15;
    step("h15_0", 8'h08, 1, 0);
    in_valid = 0;
    for (int i = 1; i < 16; i++) step("h15", 8'h08, 1, 0);
    step("h15_end", 8'h0, 0, 1);
    in_valid = 1; sel = 6; hold = 1;
    step("b2b_a1", 8'h40, 1, 0);
    step("b2b_a2", 8'h40, 1, 0);
    step("b2b_gap", 8'h0, 0, 1);
    step("b2b_b1", 8'h40, 1, 0);
    in_valid = 0;
    step("b2b_b2", 8'h40, 1, 0);
    step("b2b_end", 8'h0, 0, 1);
    in_valid = 1; sel = 4; hold = 7;
    step("ab_1", 8'h10, 1, 0);
    in_valid = 0;
    step("ab_2", 8'h10, 1, 0);
    clr = 1;
    step("ab_clr", 8'h0, 0, 1);
    clr = 0; in_valid = 1; sel = 2; hold = 5;
    step("rp_1", 8'h04, 1, 0);
    in_valid = 0;
    step("rp_2", 8'h04, 1, 0);
    rst = 1;
    step("rp_rst", 8'h0, 0, 1);
    rst = 0; which = 2;
    step("al_rst", 8'hF, 0, 1);
    in_valid = 1; mode = 0; sel = 2;
    step("al_lv2", 8'hB, 0, 1);
    mode = 1; sel = 0; hold = 1;
    step("al_p1", 8'hE, 1, 0);
    in_valid = 0;
    step("al_p2", 8'hE, 1, 0);
    step("al_end", 8'hF, 0, 1);
    @(posedge clk);
    #3;
    done = 1'b1;
    if (q.size() != 0 || bad != 0) $error("FAIL summary: pending=%0d bad=%0d", q.size(), bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decoder_n.md
Name: decoder_n

Overview:
- Parametrised, registered binary-to-one-hot decoder; successor to the combinational 2-to-4 decoder.
- Accepts a select code over a valid/ready handshake and drives the one-hot output in one of two modes:
  - level mode: the output holds until the next command or a clear.
  - pulse mode: the output is asserted for a programmable number of cycles, then released.
- Used as a channel/strobe select generator in front of muxes, enables and chip-selects.

Parameters:
- SEL_W, 2, select code width; output width OUT_W = 2**SEL_W.
- HOLD_W, 4, width of the pulse-hold count.
- ACTIVE_LOW, 0, 1 = output asserted level is 0 (inactive bits are 1); 0 = asserted level is 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command this cycle.
- sel  input  SEL_W  code to decode; sampled on accept.
- mode  input  1  0 = level, 1 = pulse; sampled on accept.
- hold  input  HOLD_W  pulse length minus one; sampled on accept; ignored in level mode.
- clr  input  1  synchronous clear of the output.
- d  output  OUT_W  registered one-hot (or one-cold when ACTIVE_LOW=1) output.
- busy  output  1  high while a pulse is in progress.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, counter=0, busy=0.
  - d = all inactive: all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1.
  - rst has priority over every other input.
- Handshake:
  - in_ready = (state==IDLE); combinational from state only, with no path from in_valid.
  - Accept = in_valid & in_ready at a rising edge.
- Decode: bit i of d is asserted iff i == the latched sel; all other bits are inactive. The ACTIVE_LOW polarity inversion applies to the whole vector.
- Latency: d reflects the command in the cycle immediately after the accept edge (1-cycle registered latency).
- States: IDLE and HOLD only.
- IDLE, on accept with mode=0:
  - d <= decode(sel); stay IDLE.
  - d holds indefinitely until a later accept or clr.
- IDLE, on accept with mode=1:
  - d <= decode(sel); counter <= hold; go to HOLD.
- IDLE, clr=1 with no accept: d <= inactive.
- IDLE, accept and clr in the same cycle: the accept wins and the command is decoded.
- HOLD:
  - If counter==0: d <= inactive; go to IDLE.
  - Otherwise: counter <= counter-1; d is unchanged.
  - d is therefore asserted for exactly hold+1 cycles; hold=0 gives a 1-cycle pulse; maximum pulse length is 2**HOLD_W cycles.
- HOLD, clr=1: abort the pulse. d <= inactive, state <= IDLE, counter <= 0 at that edge.
- in_valid during HOLD: ignored. The command is not consumed, and the source must hold it until in_ready=1.
- busy = (state==HOLD); registered-equivalent, no combinational input path.
- Back-to-back pulses:
  - The edge that releases d returns the block to IDLE, so in_ready=1 in the first cycle in which d is inactive.
  - The next accept occurs at the following edge at the earliest.
  - Consecutive pulses are therefore separated by at least one inactive cycle.
- A level-mode accept overwrites any previous level output in one cycle; there is no intermediate all-inactive cycle.
- sel, mode and hold are don't-care when no accept occurs.
- No X may propagate to d or busy after reset.

Test Plan:
- Reset check (SEL_W=2, ACTIVE_LOW=0): rst=1 for 2 cycles, then low -> d=4'b0000, busy=0, in_ready=1.
- Level mode (SEL_W=2):
  - Accept sel=0,1,2,3 on consecutive cycles with mode=0 -> d=0001, 0010, 0100, 1000, each one cycle after its accept; in_ready stays 1.
  - Then clr=1 -> d=0000 the next cycle.
- Pulse mode (SEL_W=3):
  - Accept sel=5, mode=1, hold=3 -> d=8'b0010_0000 for exactly 4 cycles, busy=1 and in_ready=0 for those cycles, then d=0, busy=0.
  - in_valid held high during HOLD is not accepted until in_ready returns.
- Boundary hold values:
  - hold=0 -> a single-cycle pulse.
  - hold=15 (HOLD_W=4) -> a 16-cycle pulse.
  - Back-to-back pulses show exactly one inactive cycle between them.
- Abort and priority:
  - clr=1 on the 2nd cycle of a hold=7 pulse -> d=0 at the next edge, in_ready=1.
  - Accept and clr together in IDLE -> the command is decoded.
  - rst=1 mid-pulse -> all outputs return to reset values at the next edge.
- Polarity (ACTIVE_LOW=1, SEL_W=2):
  - Reset -> d=4'b1111.
  - Level accept sel=2 -> d=4'b1011.
  - Pulse sel=0, hold=1 -> d=4'b1110 for 2 cycles, then 4'b1111.
